cdb_arbiter: RTL and testbench

Round-robin arbiter for the single completion broadcast bus (CDB) that feeds the ROB complete port, wakes dependents in the RS and sets ready bits in the map table. Up to NUM_REQ functional units raise completion requests. Each cycle the arbiter grants at most one of them and registers the winner's payload onto the CDB for exactly one cycle. It sits between the execute-stage functional units and the complete stage, and drives the IC_ROB_PACKET fields complete_en, complete_idx, result, rs2_value and take_branch.

---
 rtl/cdb_arbiter_pkg.sv | 26 ++
 rtl/cdb_arbiter_if.sv | 38 +++
 rtl/cdb_arbiter_rr_picker.sv | 30 +++
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default sizing, the broadcast payload struct and the
// round-robin pointer wrap helper.
package cdb_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned ROB_SZ_DEF  = 32;
  localparam int unsigned TAG_W_DEF   = 6;
  localparam int unsigned ROB_IDX_W   = $clog2(ROB_SZ_DEF);

  typedef logic [TAG_W_DEF-1:0] TAG;

  typedef struct packed {
    TAG                   tag;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN_DEF-1:0]  result;
    logic [XLEN_DEF-1:0]  rs2_value;
    logic                 take_branch;
  } CDB_PACKET;

  // Explicit wrap so non-power-of-two requester counts never reach an illegal index
  function automatic int unsigned rr_wrap_inc(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit completion requests and the registered CDB broadcast.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ROB_SZ  = 32,
  parameter int unsigned TAG_W   = 6
);
  localparam int unsigned IDX_W = $clog2(ROB_SZ);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ*IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*XLEN-1:0]  req_result;
  logic [NUM_REQ*XLEN-1:0]  req_rs2_value;
  logic [NUM_REQ-1:0]       req_take_branch;

  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [IDX_W-1:0]         cdb_rob_idx;
  logic [XLEN-1:0]          cdb_result;
  logic [XLEN-1:0]          cdb_rs2_value;
  logic                     cdb_take_branch;
  logic [SRC_W-1:0]         cdb_src;

  modport master (
    output req_valid, req_tag, req_rob_idx, req_result, req_rs2_value, req_take_branch,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_rob_idx, cdb_result, cdb_rs2_value, cdb_take_branch, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_rob_idx, req_result, req_rs2_value, req_take_branch,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_rob_idx, cdb_result, cdb_rs2_value, cdb_take_branch, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int unsigned c;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    c       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(i_ptr) + k;
      if (c >= N) c = c - N;
      if (!o_any && i_req[PW'(c)]) begin
        o_any             = 1'b1;
        o_grant[PW'(c)]   = 1'b1;
        o_idx             = PW'(c);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational grant, one-cycle registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned ROB_SZ  = ROB_SZ_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned IDX_W = $clog2(ROB_SZ);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  rs2_value;
    logic             take_branch;
  } cdb_pkt_t;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_gidx;
  logic               w_any;
  cdb_pkt_t           w_pkt;

  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   r_src;
  logic               r_valid;
  cdb_pkt_t           r_pkt;

  // Masking the request vector makes flush and reset suppress both grant and transfer
  assign w_req = (reset || flush) ? '0 : bus.req_valid;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign bus.req_ready = w_grant;

  always_comb begin
    w_pkt             = '0;
    w_pkt.tag         = bus.req_tag      [32'(w_gidx)*TAG_W +: TAG_W];
    w_pkt.rob_idx     = bus.req_rob_idx  [32'(w_gidx)*IDX_W +: IDX_W];
    w_pkt.result      = bus.req_result   [32'(w_gidx)*XLEN  +: XLEN];
    w_pkt.rs2_value   = bus.req_rs2_value[32'(w_gidx)*XLEN  +: XLEN];
    w_pkt.take_branch = bus.req_take_branch[w_gidx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_src    <= '0;
      r_valid  <= 1'b0;
      r_pkt    <= '0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_rr_ptr <= SRC_W'(rr_wrap_inc(32'(w_gidx), NUM_REQ));
        r_src    <= w_gidx;
        r_pkt    <= w_pkt;
      end
    end
  end

  assign bus.cdb_valid       = r_valid;
  assign bus.cdb_tag         = r_pkt.tag;
  assign bus.cdb_rob_idx     = r_pkt.rob_idx;
  assign bus.cdb_result      = r_pkt.result;
  assign bus.cdb_rs2_value   = r_pkt.rs2_value;
  assign bus.cdb_take_branch = r_pkt.take_branch;
  assign bus.cdb_src         = r_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int RS = 32;
  localparam int TW = 6;
  localparam int IW = 5;

  logic clock = 1'b0;
  logic reset, flush, reset3;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_REQ(N), .XLEN(XL), .ROB_SZ(RS), .TAG_W(TW)) bus ();
  cdb_arbiter #(.NUM_REQ(N), .XLEN(XL), .ROB_SZ(RS), .TAG_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  cdb_arbiter_if #(.NUM_REQ(3), .XLEN(XL), .ROB_SZ(RS), .TAG_W(TW)) bus3 ();
  cdb_arbiter #(.NUM_REQ(3), .XLEN(XL), .ROB_SZ(RS), .TAG_W(TW)) dut3 (
    .clock (clock),
    .reset (reset3),
    .flush (1'b0),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester side: each FU holds its request until it sees a grant
  logic          v     [N];
  logic [TW-1:0] s_tag [N];
  logic [IW-1:0] s_rob [N];
  logic [XL-1:0] s_res [N];
  logic [XL-1:0] s_rs2 [N];
  logic          s_tb  [N];
  int            wait_cnt [N];

  // Reference: pointer plus last broadcast record
  int            m_ptr;
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [IW-1:0] m_rob;
  logic [XL-1:0] m_res, m_rs2;
  logic          m_tb;
  int            m_src;
  logic [N-1:0]  last_ready;

  function automatic int model_pick();
    if (reset || flush) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic new_payload(input int i);
    s_tag[i] = TW'($urandom);
    s_rob[i] = IW'($urandom);
    s_res[i] = $urandom;
    s_rs2[i] = $urandom;
    s_tb[i]  = 1'($urandom);
  endtask

  task automatic cycle(output int g);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]                = v[i];
      bus.req_tag[i*TW +: TW]         = s_tag[i];
      bus.req_rob_idx[i*IW +: IW]     = s_rob[i];
      bus.req_result[i*XL +: XL]      = s_res[i];
      bus.req_rs2_value[i*XL +: XL]   = s_rs2[i];
      bus.req_take_branch[i]          = s_tb[i];
    end
    #1;
    g = model_pick();
    last_ready = bus.req_ready;
    check_val("req_ready", last_ready, (g < 0) ? 64'd0 : (64'd1 << g));
    for (int i = 0; i < N; i++) begin
      if (v[i] && !reset && !flush) begin
        if (last_ready[i]) begin
          check_val("fair_wait", 64'(wait_cnt[i] <= N - 1), 64'd1);
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
        end
      end
    end
    @(posedge clock);
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_tag = '0; m_rob = '0; m_res = '0; m_rs2 = '0; m_tb = 0; m_src = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (g >= 0) begin
      m_valid = 1; m_tag = s_tag[g]; m_rob = s_rob[g]; m_res = s_res[g];
      m_rs2 = s_rs2[g]; m_tb = s_tb[g]; m_src = g; m_ptr = (g + 1) % N;
    end else begin
      m_valid = 0;
    end
    #1;
    check_val("cdb_valid", bus.cdb_valid, m_valid);
    check_val("cdb_tag", bus.cdb_tag, m_tag);
    check_val("cdb_rob_idx", bus.cdb_rob_idx, m_rob);
    check_val("cdb_result", bus.cdb_result, m_res);
    check_val("cdb_rs2_value", bus.cdb_rs2_value, m_rs2);
    check_val("cdb_take_branch", bus.cdb_take_branch, m_tb);
    check_val("cdb_src", bus.cdb_src, 64'(m_src));
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) v[i] = 0;
  endtask

  initial begin
    int g;
    reset = 1; flush = 0; reset3 = 1;
    bus3.req_valid = '0; bus3.req_tag = '0; bus3.req_rob_idx = '0;
    bus3.req_result = '0; bus3.req_rs2_value = '0; bus3.req_take_branch = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = 0; wait_cnt[i] = 0; new_payload(i);
    end
    m_ptr = 0; m_valid = 0; m_tag = '0; m_rob = '0; m_res = '0; m_rs2 = '0; m_tb = 0; m_src = 0;
    @(posedge clock); #1;
    cycle(g); cycle(g);

    // Single request from FU2
    reset = 0;
    v[2] = 1; s_rob[2] = 5; s_res[2] = 32'hDEAD;
    cycle(g);
    check_val("t1_ready", last_ready, 64'b0100);
    check_val("t1_valid", bus.cdb_valid, 1);
    check_val("t1_rob", bus.cdb_rob_idx, 5);
    check_val("t1_result", bus.cdb_result, 32'hDEAD);
    check_val("t1_src", bus.cdb_src, 2);
    v[2] = 0;

    // All requesters continuously valid from reset
    reset = 1; cycle(g); reset = 0;
    for (int i = 0; i < N; i++) begin v[i] = 1; new_payload(i); end
    for (int k = 0; k < 5; k++) begin
      cycle(g);
      check_val("t2_order", bus.cdb_src, 64'(k % 4));
      check_val("t2_valid", bus.cdb_valid, 1);
    end
    clear_reqs();

    // Pointer at 3 with FU0 and FU3 competing
    reset = 1; cycle(g); reset = 0;
    v[2] = 1; cycle(g); v[2] = 0;
    v[0] = 1; v[3] = 1;
    cycle(g);
    check_val("t3_first", bus.cdb_src, 3);
    v[3] = 0;
    cycle(g);
    check_val("t3_second", bus.cdb_src, 0);
    v[0] = 0;

    // Flush suppresses grant for one cycle only
    v[1] = 1; flush = 1;
    cycle(g);
    check_val("t4_ready", last_ready, 0);
    check_val("t4_valid", bus.cdb_valid, 0);
    flush = 0;
    cycle(g);
    check_val("t4_after", bus.cdb_src, 1);
    check_val("t4_after_valid", bus.cdb_valid, 1);
    v[1] = 0;

    // Reset while a broadcast is on the bus
    v[0] = 1; s_res[0] = 32'h1234_5678; cycle(g);
    check_val("t6_pre_valid", bus.cdb_valid, 1);
    reset = 1;
    cycle(g);
    check_val("t6_ready", last_ready, 0);
    check_val("t6_valid", bus.cdb_valid, 0);
    check_val("t6_result", bus.cdb_result, 0);
    reset = 0; v[0] = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin v[i] = 1; new_payload(i); end
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle(g);
      if (g >= 0) v[g] = 0;
      flush = 0; reset = 0;
    end
    clear_reqs();
    cycle(g);

    // Three requesters: wrap without an illegal index
    @(negedge clock);
    reset3 = 0;
    bus3.req_valid = 3'b111;
    for (int i = 0; i < 3; i++) bus3.req_result[i*XL +: XL] = 32'(i + 16);
    for (int k = 0; k < 6; k++) begin
      #1;
      check_val("n3_ready", bus3.req_ready, 64'd1 << (k % 3));
      @(posedge clock); #1;
      check_val("n3_src", bus3.cdb_src, 64'(k % 3));
      check_val("n3_result", bus3.cdb_result, 64'(k % 3 + 16));
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
